// File: rtl/tone_sequencer.sv
// tone_sequencer: four-step programmable square-wave generator.
// Define TONE_SEQUENCER_LOOP_EN to repeat the table until stopped.
module tone_sequencer #(
  parameter int CNT_W = 26,
  parameter int TOG_W = 8
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iWrEn,
  input  logic [1:0]       iWrAddr,
  input  logic [CNT_W-1:0] iWrData,
  input  logic [TOG_W-1:0] iToggles,
  input  logic             iStart,
  input  logic             iStop,
  output logic             oWave,
  output logic             oBusy,
  output logic             oDone,
  output logic [1:0]       oStep
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNxt;

  logic [CNT_W-1:0] tbl [4];
  logic [CNT_W-1:0] hReg, hNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic [TOG_W-1:0] togCnt, togCntNxt;
  logic [TOG_W-1:0] togTgt, togTgtNxt;
  logic [TOG_W-1:0] togInc;
  logic [1:0]       step, stepNxt, stepInc;
  logic             wave, waveNxt;
  logic             done, doneNxt;
  logic             hit, lastTog;

  assign togInc  = togCnt + TOG_W'(1);
  assign stepInc = step + 2'd1;
  assign hit     = (cnt == hReg);
  assign lastTog = (togInc == togTgt);

  always_comb begin
    stateNxt  = state;
    hNxt      = hReg;
    cntNxt    = cnt;
    togCntNxt = togCnt;
    togTgtNxt = togTgt;
    stepNxt   = step;
    waveNxt   = wave;
    doneNxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart && !iStop) begin
          stateNxt  = RUN;
          stepNxt   = 2'd0;
          cntNxt    = '0;
          togCntNxt = '0;
          waveNxt   = 1'b0;
          hNxt      = tbl[0];
          togTgtNxt = (iToggles == '0) ? TOG_W'(1) : iToggles;
        end
      end
      RUN: begin
        if (iStop) begin
          stateNxt  = IDLE;
          stepNxt   = 2'd0;
          cntNxt    = '0;
          togCntNxt = '0;
          waveNxt   = 1'b0;
        end else if (!hit) begin
          cntNxt = cnt + CNT_W'(1);
        end else begin
          cntNxt  = '0;
          waveNxt = ~wave;
          if (!lastTog) begin
            togCntNxt = togInc;
          end else begin
            togCntNxt = '0;
            if (step == 2'd3) begin
`ifdef TONE_SEQUENCER_LOOP_EN
              stepNxt = 2'd0;
              hNxt    = tbl[0];
              doneNxt = 1'b1;
`else
              stateNxt = DONE;
              stepNxt  = 2'd0;
              waveNxt  = 1'b0;
              doneNxt  = 1'b1;
`endif
            end else begin
              stepNxt = stepInc;
              hNxt    = tbl[stepInc];
            end
          end
        end
      end
      DONE: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
        waveNxt  = 1'b0;
        stepNxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state  <= IDLE;
      hReg   <= '0;
      cnt    <= '0;
      togCnt <= '0;
      togTgt <= '0;
      step   <= 2'd0;
      wave   <= 1'b0;
      done   <= 1'b0;
      for (int i = 0; i < 4; i++) tbl[i] <= '0;
    end else begin
      state  <= stateNxt;
      hReg   <= hNxt;
      cnt    <= cntNxt;
      togCnt <= togCntNxt;
      togTgt <= togTgtNxt;
      step   <= stepNxt;
      wave   <= waveNxt;
      done   <= doneNxt;
      // Loads above read the old entry; a same-edge write lands after.
      if (iWrEn) tbl[iWrAddr] <= iWrData;
    end
  end

  assign oWave = wave;
  assign oBusy = (state == RUN);
  assign oDone = done;
  assign oStep = step;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench for tone_sequencer.
// Toggle and done cycles are queued as expectations, then matched.
module tb_tone_sequencer;
  localparam int CNT_W = 26;
  localparam int TOG_W = 8;

  logic             iClk = 1'b0;
  logic             iReset_n = 1'b0;
  logic             iWrEn = 1'b0;
  logic [1:0]       iWrAddr = '0;
  logic [CNT_W-1:0] iWrData = '0;
  logic [TOG_W-1:0] iToggles = '0;
  logic             iStart = 1'b0;
  logic             iStop = 1'b0;
  logic             oWave, oBusy, oDone;
  logic [1:0]       oStep;

  tone_sequencer #(.CNT_W(CNT_W), .TOG_W(TOG_W)) dut (
    .iClk(iClk), .iReset_n(iReset_n),
    .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrData(iWrData),
    .iToggles(iToggles), .iStart(iStart), .iStop(iStop),
    .oWave(oWave), .oBusy(oBusy), .oDone(oDone), .oStep(oStep)
  );

  always #5 iClk = ~iClk;

  int nCmp = 0;
  int nBad = 0;
  int expQ[$], obsQ[$], expDoneQ[$], obsDoneQ[$];
  logic [1:0] stepLog [64];
  logic       busyLog [64];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [CNT_W-1:0] d);
    iWrEn = 1'b1; iWrAddr = a; iWrData = d;
    tick();
    iWrEn = 1'b0;
  endtask

  task automatic start();
    obsQ.delete(); obsDoneQ.delete();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic capture(input int c0, input int n);
    logic prev;
    prev = oWave;
    stepLog[c0] = oStep;
    busyLog[c0] = oBusy;
    for (int c = c0 + 1; c <= c0 + n; c++) begin
      tick();
      if (oWave !== prev) obsQ.push_back(c);
      prev = oWave;
      if (oDone === 1'b1) obsDoneQ.push_back(c);
      stepLog[c] = oStep;
      busyLog[c] = oBusy;
    end
  endtask

  task automatic test_reset();
    iStart = 1'b1;
    iReset_n = 1'b0;
    tick(); tick();
    nCmp++; if (oWave !== 1'b0) begin nBad++; $display("FAIL rst_wave: got %b want 0", oWave); end
    nCmp++; if (oBusy !== 1'b0) begin nBad++; $display("FAIL rst_busy: got %b want 0", oBusy); end
    nCmp++; if (oDone !== 1'b0) begin nBad++; $display("FAIL rst_done: got %b want 0", oDone); end
    nCmp++; if (oStep !== 2'd0) begin nBad++; $display("FAIL rst_step: got %0d want 0", oStep); end
    iStart = 1'b0;
    iReset_n = 1'b1;
    tick();
    nCmp++; if (oBusy !== 1'b0) begin nBad++; $display("FAIL rst_idle: got busy %b want 0", oBusy); end
  endtask

  task automatic test_sequence();
    int e, o;
    wr(2'd0, 1); wr(2'd1, 2); wr(2'd2, 0); wr(2'd3, 3);
    iToggles = 8'd2;
    start();
    nCmp++; if (oBusy !== 1'b1 || oStep !== 2'd0 || oWave !== 1'b0) begin
      nBad++; $display("FAIL seq_entry: got busy %b step %0d wave %b want 1 0 0", oBusy, oStep, oWave);
    end
    expQ = '{2, 4, 7, 10, 11, 12, 16, 20};
    expDoneQ = '{20};
    capture(0, 24);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); nCmp++;
      if (obsQ.size() == 0) begin nBad++; $display("FAIL seq_toggle: got none want cycle %0d", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin nBad++; $display("FAIL seq_toggle: got cycle %0d want %0d", o, e); end end
    end
    nCmp++; if (obsQ.size() != 0) begin nBad++; $display("FAIL seq_extra: got %0d extra toggles want 0", obsQ.size()); end
    while (expDoneQ.size() > 0) begin
      e = expDoneQ.pop_front(); nCmp++;
      if (obsDoneQ.size() == 0) begin nBad++; $display("FAIL seq_done: got none want cycle %0d", e); end
      else begin o = obsDoneQ.pop_front(); if (o !== e) begin nBad++; $display("FAIL seq_done: got cycle %0d want %0d", o, e); end end
    end
    nCmp++; if (obsDoneQ.size() != 0) begin nBad++; $display("FAIL seq_done_extra: got %0d extra want 0", obsDoneQ.size()); end
    nCmp++; if (stepLog[3] !== 2'd0 || stepLog[4] !== 2'd1 || stepLog[10] !== 2'd2 || stepLog[12] !== 2'd3) begin
      nBad++; $display("FAIL seq_steps: got %0d %0d %0d %0d want 0 1 2 3", stepLog[3], stepLog[4], stepLog[10], stepLog[12]);
    end
    nCmp++; if (busyLog[19] !== 1'b1 || busyLog[20] !== 1'b0 || busyLog[21] !== 1'b0) begin
      nBad++; $display("FAIL seq_busy: got %b %b %b want 1 0 0", busyLog[19], busyLog[20], busyLog[21]);
    end
  endtask

  task automatic test_stop();
    wr(2'd0, 25_000_000);
    iToggles = 8'd1;
    start();
    for (int i = 0; i < 100; i++) tick();
    nCmp++; if (oBusy !== 1'b1 || oWave !== 1'b0) begin nBad++; $display("FAIL stop_pre: got busy %b wave %b want 1 0", oBusy, oWave); end
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    nCmp++; if (oBusy !== 1'b0 || oWave !== 1'b0 || oStep !== 2'd0 || oDone !== 1'b0) begin
      nBad++; $display("FAIL stop_idle: got busy %b wave %b step %0d done %b want 0 0 0 0", oBusy, oWave, oStep, oDone);
    end
    capture(0, 5);
    nCmp++; if (obsDoneQ.size() != 0) begin nBad++; $display("FAIL stop_nodone: got %0d pulses want 0", obsDoneQ.size()); end
    nCmp++; if (busyLog[5] !== 1'b0) begin nBad++; $display("FAIL stop_stay: got busy %b want 0", busyLog[5]); end
  endtask

  task automatic test_start_ignored();
    iStart = 1'b1; iStop = 1'b1;
    tick();
    iStart = 1'b0; iStop = 1'b0;
    nCmp++; if (oBusy !== 1'b0) begin nBad++; $display("FAIL both_idle: got busy %b want 0", oBusy); end
    wr(2'd0, 3); wr(2'd1, 3); wr(2'd2, 3); wr(2'd3, 3);
    iToggles = 8'd1;
    start();
    capture(0, 5);
    iStart = 1'b1;
    capture(5, 2);
    iStart = 1'b0;
    nCmp++; if (stepLog[6] !== 2'd1 || stepLog[7] !== 2'd1 || busyLog[7] !== 1'b1) begin
      nBad++; $display("FAIL restart: got step %0d %0d busy %b want 1 1 1", stepLog[6], stepLog[7], busyLog[7]);
    end
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
  endtask

  task automatic test_write_active();
    int e, o;
    wr(2'd0, 1); wr(2'd1, 0); wr(2'd2, 0); wr(2'd3, 0);
    iToggles = 8'd2;
    start();
    iWrEn = 1'b1; iWrAddr = 2'd0; iWrData = 5;
    tick();
    iWrEn = 1'b0;
    expQ = '{2, 4, 5, 6, 7, 8, 9, 10};
    expDoneQ = '{10};
    capture(1, 12);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); nCmp++;
      if (obsQ.size() == 0) begin nBad++; $display("FAIL wact_toggle: got none want cycle %0d", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin nBad++; $display("FAIL wact_toggle: got cycle %0d want %0d", o, e); end end
    end
    nCmp++; if (obsDoneQ.size() != 1 || obsDoneQ[0] != expDoneQ[0]) begin
      nBad++; $display("FAIL wact_done: got %0d pulses want 1 at cycle %0d", obsDoneQ.size(), expDoneQ[0]);
    end
    start();
    expQ = '{6, 12, 13, 14, 15, 16, 17, 18};
    expDoneQ = '{18};
    capture(0, 20);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); nCmp++;
      if (obsQ.size() == 0) begin nBad++; $display("FAIL wnext_toggle: got none want cycle %0d", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin nBad++; $display("FAIL wnext_toggle: got cycle %0d want %0d", o, e); end end
    end
    nCmp++; if (obsDoneQ.size() != 1 || obsDoneQ[0] != expDoneQ[0]) begin
      nBad++; $display("FAIL wnext_done: got %0d pulses want 1 at cycle %0d", obsDoneQ.size(), expDoneQ[0]);
    end
  endtask

  task automatic test_reset_mid();
    int e, o;
    wr(2'd0, 1); wr(2'd1, 2); wr(2'd2, 0); wr(2'd3, 3);
    iToggles = 8'd2;
    start();
    capture(0, 10);
    nCmp++; if (oStep !== 2'd2) begin nBad++; $display("FAIL rmid_step: got %0d want 2", oStep); end
    iReset_n = 1'b0;
    tick();
    iReset_n = 1'b1;
    nCmp++; if (oWave !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0 || oStep !== 2'd0) begin
      nBad++; $display("FAIL rmid_out: got wave %b busy %b done %b step %0d want 0 0 0 0", oWave, oBusy, oDone, oStep);
    end
    iToggles = 8'd0;
    start();
    expQ = '{1, 2, 3, 4};
    expDoneQ = '{4};
    capture(0, 6);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); nCmp++;
      if (obsQ.size() == 0) begin nBad++; $display("FAIL rmid_toggle: got none want cycle %0d", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin nBad++; $display("FAIL rmid_toggle: got cycle %0d want %0d", o, e); end end
    end
    nCmp++; if (obsQ.size() != 0) begin nBad++; $display("FAIL rmid_extra: got %0d extra toggles want 0", obsQ.size()); end
    nCmp++; if (obsDoneQ.size() != 1 || obsDoneQ[0] != expDoneQ[0]) begin
      nBad++; $display("FAIL rmid_done: got %0d pulses want 1 at cycle %0d", obsDoneQ.size(), expDoneQ[0]);
    end
  endtask

`ifdef TONE_SEQUENCER_LOOP_EN
  task automatic test_loop();
    int e, o;
    wr(2'd0, 0); wr(2'd1, 0); wr(2'd2, 0); wr(2'd3, 0);
    iToggles = 8'd1;
    start();
    expDoneQ = '{4, 8, 12};
    capture(0, 13);
    for (int c = 0; c <= 13; c++) begin
      nCmp++;
      if (stepLog[c] !== 2'(c % 4) || busyLog[c] !== 1'b1) begin
        nBad++; $display("FAIL loop_step: cycle %0d got step %0d busy %b want %0d 1", c, stepLog[c], busyLog[c], c % 4);
      end
    end
    while (expDoneQ.size() > 0) begin
      e = expDoneQ.pop_front(); nCmp++;
      if (obsDoneQ.size() == 0) begin nBad++; $display("FAIL loop_done: got none want cycle %0d", e); end
      else begin o = obsDoneQ.pop_front(); if (o !== e) begin nBad++; $display("FAIL loop_done: got cycle %0d want %0d", o, e); end end
    end
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    nCmp++; if (oBusy !== 1'b0) begin nBad++; $display("FAIL loop_stop: got busy %b want 0", oBusy); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_stop();
    test_start_ignored();
    test_write_active();
    test_reset_mid();
`ifdef TONE_SEQUENCER_LOOP_EN
    test_loop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
